// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   cmp_op_e    : comparison opcode encodings carried on the op port
//   cmp_state_e : control FSM states (IDLE -> RUN -> DONE)
//   cmp_eval()  : maps the final gt/lt flags onto the requested relation
package cmp_pkg;

    typedef enum logic [2:0] {
        OP_GT = 3'd0,
        OP_GE = 3'd1,
        OP_LT = 3'd2,
        OP_LE = 3'd3,
        OP_EQ = 3'd4,
        OP_NE = 3'd5
    } cmp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_e;

    // Reserved encodings (6, 7) always produce 0.
    function automatic logic cmp_eval(input logic [2:0] op, input logic gt, input logic lt);
        logic res;
        res = 1'b0;
        case (cmp_op_e'(op))
            OP_GT:   res = gt;
            OP_GE:   res = ~lt;
            OP_LT:   res = lt;
            OP_LE:   res = ~gt;
            OP_EQ:   res = ~gt & ~lt;
            OP_NE:   res = gt | lt;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational compare of one DIGIT-bit slice of the two operands.
// Ports:
//   a, b : DIGIT-bit unsigned digits
//   gt   : a > b
//   lt   : a < b
module cmp_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_uint_serial.sv
// Digit-serial comparator: compares two WIDTH-bit operands DIGIT bits per
// cycle, most-significant digit first, and reports one relation bit.
// Optional build macro: CMP_EARLY_EXIT_EN -- finish as soon as the first
// differing digit is found instead of always scanning every digit.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  : request handshake; in_ready is high only in IDLE
//   a, b                : WIDTH-bit operands, sampled on request handshake
//   op                  : 0=GT 1=GE 2=LT 3=LE 4=EQ 5=NE (6,7 give 0)
//   is_signed           : 1 = two's-complement order, 0 = unsigned
//   out_valid, out_ready: result handshake; out_valid is high only in DONE
//   y                   : result bit, held stable while out_valid is high
module cmp_uint_serial #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y
);
    import cmp_pkg::*;

    localparam int DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int NDIG     = WIDTH / DIG_SAFE;
    localparam int CNT_W    = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((DIGIT < 1) || ((WIDTH % DIG_SAFE) != 0)) begin : g_bad_cfg
            $error("cmp_uint_serial: WIDTH must be a multiple of DIGIT and DIGIT >= 1");
        end
    endgenerate

    cmp_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             gt;
    logic             lt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] a_ld;
    logic [WIDTH-1:0] b_ld;
    logic             dig_gt;
    logic             dig_lt;
    logic             gt_nxt;
    logic             lt_nxt;
    logic             last;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the rest of the datapath never needs to know about signedness.
    always_comb begin
        a_ld            = a;
        b_ld            = b;
        a_ld[WIDTH-1]   = a[WIDTH-1] ^ is_signed;
        b_ld[WIDTH-1]   = b[WIDTH-1] ^ is_signed;
    end

    cmp_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a  (a_sh[WIDTH-1 -: DIGIT]),
        .b  (b_sh[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    // The first differing digit decides the order; later digits cannot
    // override it, hence the sticky flags.
    assign gt_nxt = gt | (~gt & ~lt & dig_gt);
    assign lt_nxt = lt | (~gt & ~lt & dig_lt);

`ifdef CMP_EARLY_EXIT_EN
    assign last = (cnt == '0) | gt_nxt | lt_nxt;
`else
    assign last = (cnt == '0);
`endif

    // Operand shift registers carry no reset: every accept reloads them.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && in_valid) begin
            a_sh <= a_ld;
            b_sh <= b_ld;
        end else if (state == ST_RUN) begin
            a_sh <= a_sh << DIGIT;
            b_sh <= b_sh << DIGIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            op_r      <= 3'd0;
            y         <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r     <= op;
                        gt       <= 1'b0;
                        lt       <= 1'b0;
                        cnt      <= CNT_W'(NDIG - 1);
                        in_ready <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    gt <= gt_nxt;
                    lt <= lt_nxt;
                    if (last) begin
                        y         <= cmp_eval(op_r, gt_nxt, lt_nxt);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        y         <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    y         <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cmp_uint_serial.md
CMP_UINT_SERIAL -- requirements
Module: cmp_uint_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 8: bits compared per cycle; WIDTH % DIGIT == 0 and DIGIT >= 1, otherwise elaboration error.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops clk-rising.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: operands, sampled on request handshake.
REQ-007 SHALL have port op, input, 3 bits: 0=GT, 1=GE, 2=LT, 3=LE, 4=EQ, 5=NE, 6-7 reserved; sampled on handshake.
REQ-008 SHALL have port is_signed, input, 1 bit: 1 = two's-complement compare, 0 = unsigned; sampled on handshake.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1) and y (output, 1): result handshake and result bit.

Function
REQ-010 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-011 SHALL accept a request in IDLE when in_valid is high, load a, b, op and is_signed, clear flags gt/lt, set the digit counter to NDIG-1 (NDIG = WIDTH/DIGIT), and enter RUN.
REQ-012 SHALL, when is_signed=1, invert bit WIDTH-1 of both operands at load so the unsigned datapath yields the signed order.
REQ-013 SHALL in each RUN cycle compare the most-significant unprocessed digit, MSB-first; if gt and lt are both 0 and the digits differ, set gt (a digit > b digit) or lt; flags never change once one is set.
REQ-014 SHALL leave RUN for DONE after the counter-0 digit is processed; accept cycle = 0, RUN = cycles 1..NDIG, out_valid first high in cycle NDIG+1.
REQ-015 SHALL compute y in DONE as: GT=gt, GE=!lt, LT=lt, LE=!gt, EQ=!gt&!lt, NE=gt|lt; reserved op gives y=0.
REQ-016 SHALL hold y and out_valid stable in DONE until out_ready is high, then return to IDLE; in_ready rises in the next cycle (no overlap of requests).
REQ-017 SHALL ignore in_valid, a, b, op and is_signed outside IDLE.

Reset
REQ-018 SHALL on rst_n low, at any time including mid-RUN or DONE, immediately force state=IDLE, out_valid=0, y=0, gt=lt=0 and counter=0; in_ready=1 once reset is released; any pending result is discarded.
REQ-019 SHALL leave the operand shift registers unreset; they are reloaded on every accept.

Configuration
REQ-020 SHALL, with macro CMP_EARLY_EXIT_EN defined, leave RUN for DONE in the cycle after gt or lt first becomes set; if the first differing digit has index k (0 = most significant), out_valid is first high in cycle k+2; equal operands take NDIG+1.
REQ-021 SHALL, without CMP_EARLY_EXIT_EN, always spend exactly NDIG cycles in RUN; results are identical in both builds.

Structure
REQ-022 SHALL place typedef cmp_op_e (op encodings) and the FSM state enum cmp_state_e in shared package cmp_pkg.
REQ-023 SHALL instantiate one combinational sub-module cmp_digit (DIGIT-bit inputs, gt/lt outputs) for the per-cycle digit compare.

Verification (WIDTH=64, DIGIT=8)
REQ-024 SHALL check: op=GT, unsigned, a=0xFFFF_FFFF_FFFF_FFFF, b=0 -> y=1, out_valid in cycle 9 (cycle 2 with CMP_EARLY_EXIT_EN).
REQ-025 SHALL check: op=LT, a=0x8000_0000_0000_0000, b=1 -> y=1 with is_signed=1 and y=0 with is_signed=0.
REQ-026 SHALL check: op=EQ, a=b=0x0123_4567_89AB_CDEF -> y=1, out_valid in cycle 9 in both builds; op=6 with the same operands -> y=0.
REQ-027 SHALL check: op=GE, a=1, b=0 (difference only in the last digit) -> y=1, out_valid in cycle 9 in both builds.
REQ-028 SHALL check: out_ready held low 5 cycles in DONE -> y and out_valid stable, in_ready=0, and an in_valid pulse ignored; after out_ready=1, in_ready=1 in the next cycle.
REQ-029 SHALL check: rst_n pulsed low in cycle 4 of RUN -> out_valid=0 and y=0 immediately, in_ready=1 after release, and the next request completes correctly.
